img_op_sequencer: RTL

IMG_OP_SEQUENCER -- requirements
Module: img_op_sequencer

---
 rtl/img_op_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/img_op_sequencer.sv
// Command sequencer for an image pipeline: decodes register ops in IDLE and
// hands SRAM ownership to the RX, TX and two-pass separable convolution engines.
module img_op_sequencer #(
    parameter int DATA_W  = 8,
    parameter int DIM_W   = 8,
    parameter int SIGMA_W = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [3:0]         op,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DIM_W-1:0]   nrows,
    output logic [DIM_W-1:0]   ncols,
    output logic [SIGMA_W-1:0] sigma,
    output logic               rx_start,
    output logic               tx_start,
    output logic               conv_start,
    input  logic               rx_busy,
    input  logic               tx_busy,
    input  logic               conv_busy,
    output logic               conv_swap,
    output logic [1:0]         sram_sel
);

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_GET_NROWS = 4'd1;
    localparam logic [3:0] OP_GET_NCOLS = 4'd2;
    localparam logic [3:0] OP_GET_SIGMA = 4'd3;
    localparam logic [3:0] OP_SET_NROWS = 4'd4;
    localparam logic [3:0] OP_SET_NCOLS = 4'd5;
    localparam logic [3:0] OP_SET_SIGMA = 4'd6;
    localparam logic [3:0] OP_IMG_RX    = 4'd7;
    localparam logic [3:0] OP_IMG_TX    = 4'd8;
    localparam logic [3:0] OP_CONV      = 4'd9;
    localparam logic [3:0] OP_SET_MODE  = 4'd10;
    localparam logic [3:0] OP_GET_STAT  = 4'd11;
    localparam logic [3:0] OP_CLR_ERR   = 4'd12;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_RX   = 2'd1;
    localparam logic [1:0] SEL_TX   = 2'd2;
    localparam logic [1:0] SEL_CONV = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_REQ,
        S_RX_RUN,
        S_TX_REQ,
        S_TX_RUN,
        S_P1_REQ,
        S_P1_RUN,
        S_P2_REQ,
        S_P2_RUN,
        S_FINISH
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_dout;
    logic               r_err;
    logic               r_conv_swap;
    logic [DIM_W-1:0]   r_nrows;
    logic [DIM_W-1:0]   r_ncols;
    logic [SIGMA_W-1:0] r_sigma;
    logic [1:0]         r_mode;

    state_t             w_state_next;
    logic [DATA_W-1:0]  w_dout_next;
    logic               w_err_next;
    logic               w_swap_next;
    logic [DIM_W-1:0]   w_nrows_next;
    logic [DIM_W-1:0]   w_ncols_next;
    logic [SIGMA_W-1:0] w_sigma_next;
    logic [1:0]         w_mode_next;
    logic               w_rx_start;
    logic               w_tx_start;
    logic               w_conv_start;
    logic [1:0]         w_sram_sel;
    logic [DIM_W-1:0]   w_nrows_eff;
    logic [DIM_W-1:0]   w_ncols_eff;
    logic               w_unused;

    // A zero dimension would stall the engines, so it reads back and drives as 1.
    assign w_nrows_eff = (r_nrows == '0) ? DIM_W'(1) : r_nrows;
    assign w_ncols_eff = (r_ncols == '0) ? DIM_W'(1) : r_ncols;
    assign w_unused    = ^din;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dout_next  = r_dout;
        w_err_next   = r_err;
        w_swap_next  = r_conv_swap;
        w_nrows_next = r_nrows;
        w_ncols_next = r_ncols;
        w_sigma_next = r_sigma;
        w_mode_next  = r_mode;
        w_rx_start   = 1'b0;
        w_tx_start   = 1'b0;
        w_conv_start = 1'b0;
        w_sram_sel   = SEL_HOLD;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    case (op)
                        OP_NOP:       ;
                        OP_GET_NROWS: w_dout_next  = DATA_W'(w_nrows_eff);
                        OP_GET_NCOLS: w_dout_next  = DATA_W'(w_ncols_eff);
                        OP_GET_SIGMA: w_dout_next  = DATA_W'(r_sigma);
                        OP_SET_NROWS: w_nrows_next = din[DIM_W-1:0];
                        OP_SET_NCOLS: w_ncols_next = din[DIM_W-1:0];
                        OP_SET_SIGMA: w_sigma_next = din[SIGMA_W-1:0];
                        OP_IMG_RX:    w_state_next = S_RX_REQ;
                        OP_IMG_TX:    w_state_next = S_TX_REQ;
                        OP_CONV: begin
                            // Swap is settled here, before any start is raised.
                            if (r_mode[0]) begin
                                w_state_next = S_P1_REQ;
                                w_swap_next  = 1'b0;
                            end else if (r_mode[1]) begin
                                w_state_next = S_P2_REQ;
                                w_swap_next  = 1'b1;
                            end else begin
                                w_state_next = S_FINISH;
                            end
                        end
                        OP_SET_MODE:  w_mode_next  = din[1:0];
                        OP_GET_STAT:  w_dout_next  = DATA_W'({r_mode, r_err});
                        OP_CLR_ERR:   w_err_next   = 1'b0;
                        default:      w_err_next   = 1'b1;
                    endcase
                end
            end
            S_RX_REQ: begin
                w_rx_start = 1'b1;
                w_sram_sel = SEL_RX;
                if (rx_busy) w_state_next = S_RX_RUN;
            end
            S_RX_RUN: begin
                w_sram_sel = SEL_RX;
                if (!rx_busy) w_state_next = S_FINISH;
            end
            S_TX_REQ: begin
                w_tx_start = 1'b1;
                w_sram_sel = SEL_TX;
                if (tx_busy) w_state_next = S_TX_RUN;
            end
            S_TX_RUN: begin
                w_sram_sel = SEL_TX;
                if (!tx_busy) w_state_next = S_FINISH;
            end
            S_P1_REQ: begin
                w_conv_start = 1'b1;
                w_sram_sel   = SEL_CONV;
                if (conv_busy) w_state_next = S_P1_RUN;
            end
            S_P1_RUN: begin
                w_sram_sel = SEL_CONV;
                if (!conv_busy) begin
                    // Row pass finished and engine idle: safe point to flip direction.
                    if (r_mode[1]) begin
                        w_state_next = S_P2_REQ;
                        w_swap_next  = 1'b1;
                    end else begin
                        w_state_next = S_FINISH;
                    end
                end
            end
            S_P2_REQ: begin
                w_conv_start = 1'b1;
                w_sram_sel   = SEL_CONV;
                if (conv_busy) w_state_next = S_P2_RUN;
            end
            S_P2_RUN: begin
                w_sram_sel = SEL_CONV;
                if (!conv_busy) w_state_next = S_FINISH;
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout      <= '0;
            r_err       <= 1'b0;
            r_conv_swap <= 1'b0;
            r_nrows     <= DIM_W'(8);
            r_ncols     <= DIM_W'(8);
            r_sigma     <= '0;
            r_mode      <= 2'b11;
        end else begin
            r_dout      <= w_dout_next;
            r_err       <= w_err_next;
            r_conv_swap <= w_swap_next;
            r_nrows     <= w_nrows_next;
            r_ncols     <= w_ncols_next;
            r_sigma     <= w_sigma_next;
            r_mode      <= w_mode_next;
        end
    end

    assign dout       = r_dout;
    assign err        = r_err;
    assign conv_swap  = r_conv_swap;
    assign nrows      = w_nrows_eff;
    assign ncols      = w_ncols_eff;
    assign sigma      = r_sigma;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign rx_start   = w_rx_start;
    assign tx_start   = w_tx_start;
    assign conv_start = w_conv_start;
    assign sram_sel   = w_sram_sel;

endmodule
